// File: rtl/counter_multi_pkg.sv
// Shared constants and status-word layout for the multi-channel countdown timer.
// Contents:
//   MaxNch, DefWidth, DefPw        - parameter limits and defaults
//   StatBusy/StatSticky/StatOverrun - bit positions of the per-channel status word
//   ch_status_t / pack_status      - status word type and builder for the register bank
package counter_multi_pkg;

  localparam int unsigned MaxNch   = 16;
  localparam int unsigned DefWidth = 32;
  localparam int unsigned DefPw    = 16;

  // Per-channel status word as seen by the register bank: {overrun, expired_sticky, busy}
  localparam int unsigned StatusWidth = 3;
  localparam int unsigned StatBusy    = 0;
  localparam int unsigned StatSticky  = 1;
  localparam int unsigned StatOverrun = 2;

  typedef struct packed {
    logic overrun;
    logic expired_sticky;
    logic busy;
  } ch_status_t;

  function automatic ch_status_t pack_status(input logic busy, input logic sticky,
                                             input logic overrun);
    ch_status_t s;
    s.overrun        = overrun;
    s.expired_sticky = sticky;
    s.busy           = busy;
    return s;
  endfunction

endpackage

// File: rtl/counter_multi_ch.sv
// One countdown channel: load/run, abort, optional auto-reload, sticky flags.
// Ports:
//   clk_i, rstn_i        - clock, asynchronous active-low reset
//   ch_tick_i            - shared prescaled tick
//   n_load_i             - load value
//   start_i, stop_i      - load-and-run / abort strobes (stop has priority)
//   reload_en_i          - periodic mode, sampled at expiry
//   clear_i              - clears sticky flags
//   count_o, busy_o      - current count, channel running
//   expired_o            - one-cycle expiry pulse
//   expired_sticky_o     - held until clear
//   overrun_o            - expiry while sticky was already set
module counter_multi_ch
  import counter_multi_pkg::*;
#(
  parameter int unsigned Width = DefWidth
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             ch_tick_i,
  input  logic [Width-1:0] n_load_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             reload_en_i,
  input  logic             clear_i,
  output logic [Width-1:0] count_o,
  output logic             busy_o,
  output logic             expired_o,
  output logic             expired_sticky_o,
  output logic             overrun_o
);

  logic [Width-1:0] count_q, count_d;
  logic [Width-1:0] reload_q, reload_d;
  logic             busy_q, busy_d;
  logic             expired_q, expired_d;
  logic             sticky_q, sticky_d;
  logic             overrun_q, overrun_d;

  always_comb begin
    count_d   = count_q;
    reload_d  = reload_q;
    busy_d    = busy_q;
    expired_d = 1'b0;

    if (stop_i) begin
      busy_d  = 1'b0;
      count_d = '0;
    end else if (start_i) begin
      reload_d = n_load_i;
      count_d  = n_load_i;
      if (n_load_i != '0) begin
        busy_d = 1'b1;
      end else begin
        // Zero load expires immediately and never reloads.
        busy_d    = 1'b0;
        expired_d = 1'b1;
      end
    end else if (ch_tick_i && busy_q) begin
      if (count_q > Width'(1)) begin
        count_d = count_q - Width'(1);
      end else if (count_q == Width'(1)) begin
        expired_d = 1'b1;
        if (reload_en_i) begin
          count_d = reload_q;
        end else begin
          count_d = '0;
          busy_d  = 1'b0;
        end
      end
    end
  end

  // A clear colliding with an expiry keeps the new expiry but drops overrun.
  always_comb begin
    sticky_d  = sticky_q;
    overrun_d = overrun_q;
    if (clear_i) begin
      sticky_d  = expired_d;
      overrun_d = 1'b0;
    end else if (expired_d) begin
      sticky_d  = 1'b1;
      overrun_d = overrun_q | sticky_q;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      count_q   <= '0;
      reload_q  <= '0;
      busy_q    <= 1'b0;
      expired_q <= 1'b0;
      sticky_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      reload_q  <= reload_d;
      busy_q    <= busy_d;
      expired_q <= expired_d;
      sticky_q  <= sticky_d;
      overrun_q <= overrun_d;
    end
  end

  assign count_o          = count_q;
  assign busy_o           = busy_q;
  assign expired_o        = expired_q;
  assign expired_sticky_o = sticky_q;
  assign overrun_o        = overrun_q;

endmodule

// File: rtl/counter_multi.sv
// Multi-channel programmable countdown timer with a shared tick prescaler.
// Ports:
//   clk_i, rstn_i         - clock, asynchronous active-low reset
//   timer_tick_i          - raw tick strobe
//   prescale_i            - channel tick every prescale+1 raw ticks
//   n_load_i              - per-channel load values, channel i at [i*WIDTH +: WIDTH]
//   start_i, stop_i       - per-channel load-and-run / abort strobes
//   reload_en_i, clear_i  - per-channel periodic mode / sticky-flag clear
//   count_o               - per-channel counts, same packing as n_load_i
//   busy_o, expired_o, expired_sticky_o, overrun_o - per-channel status
module counter_multi
  import counter_multi_pkg::*;
#(
  parameter int unsigned NCH   = 4,
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned PW    = DefPw
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 timer_tick_i,
  input  logic [PW-1:0]        prescale_i,
  input  logic [NCH*WIDTH-1:0] n_load_i,
  input  logic [NCH-1:0]       start_i,
  input  logic [NCH-1:0]       stop_i,
  input  logic [NCH-1:0]       reload_en_i,
  input  logic [NCH-1:0]       clear_i,
  output logic [NCH*WIDTH-1:0] count_o,
  output logic [NCH-1:0]       busy_o,
  output logic [NCH-1:0]       expired_o,
  output logic [NCH-1:0]       expired_sticky_o,
  output logic [NCH-1:0]       overrun_o
);

  logic [PW-1:0] pre_cnt_q, pre_cnt_d;
  logic          ch_tick;

  // Out-of-range pre_cnt (after prescale shrinks) simply wraps through 2^PW.
  assign ch_tick = timer_tick_i && (pre_cnt_q == prescale_i);

  always_comb begin
    pre_cnt_d = pre_cnt_q;
    if (timer_tick_i) begin
      pre_cnt_d = ch_tick ? '0 : pre_cnt_q + PW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    counter_multi_ch #(
      .Width(WIDTH)
    ) u_ch (
      .clk_i           (clk_i),
      .rstn_i          (rstn_i),
      .ch_tick_i       (ch_tick),
      .n_load_i        (n_load_i[i*WIDTH +: WIDTH]),
      .start_i         (start_i[i]),
      .stop_i          (stop_i[i]),
      .reload_en_i     (reload_en_i[i]),
      .clear_i         (clear_i[i]),
      .count_o         (count_o[i*WIDTH +: WIDTH]),
      .busy_o          (busy_o[i]),
      .expired_o       (expired_o[i]),
      .expired_sticky_o(expired_sticky_o[i]),
      .overrun_o       (overrun_o[i])
    );
  end

endmodule

// File: tb/tb_counter_multi.sv
module tb_counter_multi;

  localparam int unsigned NCH   = 4;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned PW    = 8;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic                 timer_tick;
  logic [PW-1:0]        prescale;
  logic [NCH*WIDTH-1:0] n_load;
  logic [NCH-1:0]       start, stop, reload_en, clear;
  logic [NCH*WIDTH-1:0] count;
  logic [NCH-1:0]       busy, expired, expired_sticky, overrun;

  int n_tests = 0;
  int n_fail  = 0;

  counter_multi #(
    .NCH  (NCH),
    .WIDTH(WIDTH),
    .PW   (PW)
  ) dut (
    .clk_i           (clk),
    .rstn_i          (rstn),
    .timer_tick_i    (timer_tick),
    .prescale_i      (prescale),
    .n_load_i        (n_load),
    .start_i         (start),
    .stop_i          (stop),
    .reload_en_i     (reload_en),
    .clear_i         (clear),
    .count_o         (count),
    .busy_o          (busy),
    .expired_o       (expired),
    .expired_sticky_o(expired_sticky),
    .overrun_o       (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        tick;
    logic [3:0]  st, sp, rl, cl;
    logic [63:0] nload;
    logic [63:0] e_cnt;
    logic [3:0]  e_busy, e_exp, e_sticky, e_ovr;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input string nm, input logic tk, input logic [3:0] st, input logic [3:0] sp,
                     input logic [3:0] rl, input logic [3:0] cl, input logic [63:0] nl,
                     input logic [63:0] ec, input logic [3:0] eb, input logic [3:0] ee,
                     input logic [3:0] es, input logic [3:0] eo);
    vec_t v;
    v.name = nm; v.tick = tk; v.st = st; v.sp = sp; v.rl = rl; v.cl = cl; v.nload = nl;
    v.e_cnt = ec; v.e_busy = eb; v.e_exp = ee; v.e_sticky = es; v.e_ovr = eo;
    tbl.push_back(v);
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    timer_tick = 1'b0; start = '0; stop = '0; reload_en = '0; clear = '0; n_load = '0;
  endtask

  initial begin
    rstn = 1'b0;
    prescale = '0;
    idle_inputs();

    // Stimulus table: {inputs applied for one edge} -> {outputs after that edge}
    //   name           tk st     sp     rl     cl     nload                  count                  busy   exp    sticky ovr
    add("os_start",    0, 4'h1, 4'h0, 4'h0, 4'h0, 64'h0000_0000_0000_0003, 64'h0000_0000_0000_0003, 4'h1, 4'h0, 4'h0, 4'h0);
    add("os_tick1",    1, 4'h0, 4'h0, 4'h0, 4'h0, 64'h0,                   64'h0000_0000_0000_0002, 4'h1, 4'h0, 4'h0, 4'h0);
    add("os_tick2",    1, 4'h0, 4'h0, 4'h0, 4'h0, 64'h0,                   64'h0000_0000_0000_0001, 4'h1, 4'h0, 4'h0, 4'h0);
    add("os_tick3",    1, 4'h0, 4'h0, 4'h0, 4'h0, 64'h0,                   64'h0,                   4'h0, 4'h1, 4'h1, 4'h0);
    add("os_idle",     0, 4'h0, 4'h0, 4'h0, 4'h0, 64'h0,                   64'h0,                   4'h0, 4'h0, 4'h1, 4'h0);
    add("cc_start",    0, 4'h1, 4'h0, 4'h0, 4'h0, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0001, 4'h1, 4'h0, 4'h1, 4'h0);
    add("cc_tick_clr", 1, 4'h0, 4'h0, 4'h0, 4'h1, 64'h0,                   64'h0,                   4'h0, 4'h1, 4'h1, 4'h0);
    add("cc_clr",      0, 4'h0, 4'h0, 4'h0, 4'h1, 64'h0,                   64'h0,                   4'h0, 4'h0, 4'h0, 4'h0);
    add("ov_start1",   0, 4'h1, 4'h0, 4'h0, 4'h0, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0001, 4'h1, 4'h0, 4'h0, 4'h0);
    add("ov_tick1",    1, 4'h0, 4'h0, 4'h0, 4'h0, 64'h0,                   64'h0,                   4'h0, 4'h1, 4'h1, 4'h0);
    add("ov_start2",   0, 4'h1, 4'h0, 4'h0, 4'h0, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0001, 4'h1, 4'h0, 4'h1, 4'h0);
    add("ov_tick2",    1, 4'h0, 4'h0, 4'h0, 4'h0, 64'h0,                   64'h0,                   4'h0, 4'h1, 4'h1, 4'h1);
    add("ov_clr",      0, 4'h0, 4'h0, 4'h0, 4'h1, 64'h0,                   64'h0,                   4'h0, 4'h0, 4'h0, 4'h0);
    add("pr_start5",   0, 4'h4, 4'h0, 4'h0, 4'h0, 64'h0000_0005_0000_0000, 64'h0000_0005_0000_0000, 4'h4, 4'h0, 4'h0, 4'h0);
    add("pr_tick",     1, 4'h0, 4'h0, 4'h0, 4'h0, 64'h0,                   64'h0000_0004_0000_0000, 4'h4, 4'h0, 4'h0, 4'h0);
    add("pr_restart",  1, 4'h4, 4'h0, 4'h0, 4'h0, 64'h0000_0007_0000_0000, 64'h0000_0007_0000_0000, 4'h4, 4'h0, 4'h0, 4'h0);
    add("pr_stop",     1, 4'h4, 4'h4, 4'h0, 4'h0, 64'h0000_0007_0000_0000, 64'h0,                   4'h0, 4'h0, 4'h0, 4'h0);
    add("pr_n0",       0, 4'h4, 4'h0, 4'h4, 4'h0, 64'h0,                   64'h0,                   4'h0, 4'h4, 4'h4, 4'h0);
    add("pr_n0_tick",  1, 4'h0, 4'h0, 4'h4, 4'h0, 64'h0,                   64'h0,                   4'h0, 4'h0, 4'h4, 4'h0);
    add("pr_clr",      0, 4'h0, 4'h0, 4'h0, 4'h4, 64'h0,                   64'h0,                   4'h0, 4'h0, 4'h0, 4'h0);
    add("ind_start",   0, 4'hf, 4'h0, 4'h0, 4'h0, 64'h0004_0003_0002_0001, 64'h0004_0003_0002_0001, 4'hf, 4'h0, 4'h0, 4'h0);
    add("ind_tick1",   1, 4'h0, 4'h0, 4'h0, 4'h0, 64'h0,                   64'h0003_0002_0001_0000, 4'he, 4'h1, 4'h1, 4'h0);
    add("ind_tick2",   1, 4'h0, 4'h0, 4'h0, 4'h0, 64'h0,                   64'h0002_0001_0000_0000, 4'hc, 4'h2, 4'h3, 4'h0);
    add("ind_tick3",   1, 4'h0, 4'h0, 4'h0, 4'h0, 64'h0,                   64'h0001_0000_0000_0000, 4'h8, 4'h4, 4'h7, 4'h0);
    add("ind_tick4",   1, 4'h0, 4'h0, 4'h0, 4'h0, 64'h0,                   64'h0,                   4'h0, 4'h8, 4'hf, 4'h0);
    add("ind_idle",    0, 4'h0, 4'h0, 4'h0, 4'h0, 64'h0,                   64'h0,                   4'h0, 4'h0, 4'hf, 4'h0);
    add("ind_clr",     0, 4'h0, 4'h0, 4'h0, 4'hf, 64'h0,                   64'h0,                   4'h0, 4'h0, 4'h0, 4'h0);

    // Reset state
    repeat (2) step();
    check("rst_count", count, 64'h0);
    check("rst_flags", {48'h0, busy, expired, expired_sticky, overrun}, 64'h0);
    @(negedge clk);
    rstn = 1'b1;
    step();

    // Reset mid-count: asynchronous clear, nothing fires afterwards
    start = 4'h1; n_load = 64'h0000_0000_0000_0005;
    step();
    idle_inputs(); timer_tick = 1'b1;
    step();
    step();
    check("mid_count", count, 64'h0000_0000_0000_0003);
    idle_inputs();
    #2 rstn = 1'b0;
    #1;
    check("async_rst_count", count, 64'h0);
    check("async_rst_flags", {48'h0, busy, expired, expired_sticky, overrun}, 64'h0);
    @(negedge clk);
    rstn = 1'b1;
    timer_tick = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      check("post_rst_quiet", {56'h0, busy, expired}, 64'h0);
    end
    idle_inputs();
    step();

    // Table-driven vectors, prescale = 0
    foreach (tbl[i]) begin
      timer_tick = tbl[i].tick;
      start      = tbl[i].st;
      stop       = tbl[i].sp;
      reload_en  = tbl[i].rl;
      clear      = tbl[i].cl;
      n_load     = tbl[i].nload;
      step();
      check({tbl[i].name, ".count"},   count,                   tbl[i].e_cnt);
      check({tbl[i].name, ".busy"},    {60'h0, busy},           {60'h0, tbl[i].e_busy});
      check({tbl[i].name, ".expired"}, {60'h0, expired},        {60'h0, tbl[i].e_exp});
      check({tbl[i].name, ".sticky"},  {60'h0, expired_sticky}, {60'h0, tbl[i].e_sticky});
      check({tbl[i].name, ".overrun"}, {60'h0, overrun},        {60'h0, tbl[i].e_ovr});
    end
    idle_inputs();
    step();

    // Periodic channel 1 with prescale = 2: channel ticks on raw ticks 3, 6, 9, 12
    prescale  = 8'd2;
    reload_en = 4'h2;
    start     = 4'h2;
    n_load    = 64'h0000_0000_0002_0000;
    step();
    start = '0; n_load = '0;
    check("per_load", count, 64'h0000_0000_0002_0000);
    for (int k = 1; k <= 12; k++) begin
      logic [15:0] exp_c;
      exp_c = ((k % 6) >= 3) ? 16'd1 : 16'd2;
      timer_tick = 1'b1;
      step();
      timer_tick = 1'b0;
      check($sformatf("per_cnt_%0d", k), count, {32'h0, exp_c, 16'h0});
      check($sformatf("per_exp_%0d", k), {60'h0, expired},
            {60'h0, ((k == 6) || (k == 12)) ? 4'h2 : 4'h0});
      check($sformatf("per_busy_%0d", k), {60'h0, busy}, 64'h2);
      step();
      check($sformatf("per_exp_off_%0d", k), {60'h0, expired}, 64'h0);
      if (k == 6) begin
        check("per_sticky_6", {60'h0, expired_sticky, overrun}, {60'h0, 8'h20});
      end
    end
    check("per_overrun_12", {56'h0, expired_sticky, overrun}, {56'h0, 8'h22});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
